// File: rtl/fft_stage_scheduler.sv
// Butterfly pair scheduler for an in-place radix-2 FFT: walks every stage and issues (idx_a, idx_b, tw_idx) over valid/ready.
// Optional inter-stage drain barrier enabled by defining FFT_SCHED_STAGE_BARRIER_EN (adds the bf_idle input).
module fft_stage_scheduler #(
    parameter int SAMPLES = 8,
    localparam int LOG2N = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
`ifdef FFT_SCHED_STAGE_BARRIER_EN
    input  logic             bf_idle,
`endif
    input  logic             pair_ready,
    output logic             pair_valid,
    output logic [LOG2N-1:0] idx_a,
    output logic [LOG2N-1:0] idx_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [LOG2N-1:0] stage,
    output logic             last_in_stage,
    output logic             busy,
    output logic             done
);
    localparam int W  = LOG2N + 1;
    localparam int PW = 3 * LOG2N;
    localparam logic [W-1:0]     ONE_W      = W'(1);
    localparam logic [W-1:0]     SAMPLES_W  = W'(SAMPLES);
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);

`ifdef FFT_SCHED_STAGE_BARRIER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    logic [W-1:0]     r_l;
    logic [W-1:0]     r_j;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
    logic             r_final;
    logic             w_final_n;
`endif

    logic [W-1:0]     w_half;
    logic [W-1:0]     w_j_inc;
    logic [W-1:0]     w_l_inc;
    logic [W-1:0]     w_adv_l;
    logic [W-1:0]     w_adv_j;
    logic [LOG2N-1:0] w_adv_stage;
    logic             w_stage_end;
    logic             w_hs;

    state_t           w_state_n;
    logic [W-1:0]     w_l_n;
    logic [W-1:0]     w_j_n;
    logic [LOG2N-1:0] w_stage_n;
    logic [PW-1:0]    w_fields_n;
    logic             w_valid_n;
    logic             w_done_n;

    // Packs {last_in_stage, tw_idx, idx_b, idx_a} for a given (stage, group base, offset).
    function automatic logic [PW-1:0] pair_fields(input logic [LOG2N-1:0] s,
                                                  input logic [W-1:0] l,
                                                  input logic [W-1:0] j);
        logic [W-1:0] half;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sh;
        logic [W-1:0] tw;
        logic [W-1:0] last_l;
        half   = ONE_W << s;
        a      = l + j;
        b      = a + half;
        sh     = W'(LOG2N - 1) - W'(s);
        tw     = j << sh;
        last_l = SAMPLES_W - (half << 1);
        pair_fields = {((l == last_l) && (j == (half - ONE_W))), tw[LOG2N-2:0], b[LOG2N-1:0], a[LOG2N-1:0]};
    endfunction

    // Counter advance applied on every accepted pair.
    always_comb begin
        w_half      = ONE_W << stage;
        w_j_inc     = r_j + ONE_W;
        w_l_inc     = r_l + (w_half << 1);
        w_adv_j     = w_j_inc;
        w_adv_l     = r_l;
        w_adv_stage = stage;
        w_stage_end = 1'b0;
        w_hs        = pair_valid && pair_ready;
        if (w_j_inc == w_half) begin
            w_adv_j = {W{1'b0}};
            if (w_l_inc == SAMPLES_W) begin
                w_adv_l     = {W{1'b0}};
                w_adv_stage = stage + 1'b1;
                w_stage_end = 1'b1;
            end else begin
                w_adv_l = w_l_inc;
            end
        end else begin
            w_adv_j = w_j_inc;
        end
    end

    // Next-state and next-output computation; abort overrides everything.
    always_comb begin
        w_state_n  = r_state;
        w_l_n      = r_l;
        w_j_n      = r_j;
        w_stage_n  = stage;
        w_fields_n = {last_in_stage, tw_idx, idx_b, idx_a};
        w_valid_n  = pair_valid;
        w_done_n   = 1'b0;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
        w_final_n  = r_final;
`endif
        if (abort) begin
            w_state_n  = S_IDLE;
            w_l_n      = {W{1'b0}};
            w_j_n      = {W{1'b0}};
            w_stage_n  = {LOG2N{1'b0}};
            w_fields_n = {PW{1'b0}};
            w_valid_n  = 1'b0;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
            w_final_n  = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_n  = S_ISSUE;
                        w_l_n      = {W{1'b0}};
                        w_j_n      = {W{1'b0}};
                        w_stage_n  = {LOG2N{1'b0}};
                        w_fields_n = pair_fields({LOG2N{1'b0}}, {W{1'b0}}, {W{1'b0}});
                        w_valid_n  = 1'b1;
                    end else begin
                        w_valid_n  = 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_hs && w_stage_end && (stage == LAST_STAGE)) begin
                        w_l_n      = {W{1'b0}};
                        w_j_n      = {W{1'b0}};
                        w_stage_n  = {LOG2N{1'b0}};
                        w_fields_n = {PW{1'b0}};
                        w_valid_n  = 1'b0;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
                        w_state_n  = S_DRAIN;
                        w_final_n  = 1'b1;
`else
                        w_state_n  = S_DONE;
                        w_done_n   = 1'b1;
`endif
                    end else if (w_hs) begin
                        w_l_n      = w_adv_l;
                        w_j_n      = w_adv_j;
                        w_stage_n  = w_adv_stage;
                        w_fields_n = pair_fields(w_adv_stage, w_adv_l, w_adv_j);
`ifdef FFT_SCHED_STAGE_BARRIER_EN
                        if (w_stage_end) begin
                            w_state_n = S_DRAIN;
                            w_valid_n = 1'b0;
                        end else begin
                            w_valid_n = 1'b1;
                        end
`endif
                    end else begin
                        w_valid_n  = 1'b1;
                    end
                end
`ifdef FFT_SCHED_STAGE_BARRIER_EN
                S_DRAIN: begin
                    if (bf_idle && r_final) begin
                        w_state_n = S_DONE;
                        w_done_n  = 1'b1;
                        w_final_n = 1'b0;
                    end else if (bf_idle) begin
                        w_state_n = S_ISSUE;
                        w_valid_n = 1'b1;
                    end else begin
                        w_valid_n = 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    w_state_n = S_IDLE;
                    w_valid_n = 1'b0;
                end
                default: begin
                    w_state_n  = S_IDLE;
                    w_l_n      = {W{1'b0}};
                    w_j_n      = {W{1'b0}};
                    w_stage_n  = {LOG2N{1'b0}};
                    w_fields_n = {PW{1'b0}};
                    w_valid_n  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_l           <= {W{1'b0}};
            r_j           <= {W{1'b0}};
            stage         <= {LOG2N{1'b0}};
            pair_valid    <= 1'b0;
            idx_a         <= {LOG2N{1'b0}};
            idx_b         <= {LOG2N{1'b0}};
            tw_idx        <= {(LOG2N-1){1'b0}};
            last_in_stage <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
            r_final       <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_l        <= w_l_n;
            r_j        <= w_j_n;
            stage      <= w_stage_n;
            pair_valid <= w_valid_n;
            {last_in_stage, tw_idx, idx_b, idx_a} <= w_fields_n;
            busy       <= (w_state_n != S_IDLE);
            done       <= w_done_n;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
            r_final    <= w_final_n;
`endif
        end
    end
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler (SAMPLES=8): full runs, backpressure, start-while-busy, abort, async reset, optional barrier.
module tb_fft_stage_scheduler;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       pair_ready;
    logic       pair_valid;
    logic [2:0] idx_a;
    logic [2:0] idx_b;
    logic [1:0] tw_idx;
    logic [2:0] stage;
    logic       last_in_stage;
    logic       busy;
    logic       done;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
    logic       bf_idle;
`endif

    int errors = 0;
    int checks = 0;

    int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_st [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    fft_stage_scheduler #(.SAMPLES(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
`ifdef FFT_SCHED_STAGE_BARRIER_EN
        .bf_idle       (bf_idle),
`endif
        .pair_ready    (pair_ready),
        .pair_valid    (pair_valid),
        .idx_a         (idx_a),
        .idx_b         (idx_b),
        .tw_idx        (tw_idx),
        .stage         (stage),
        .last_in_stage (last_in_stage),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pair_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_a"},     32'(idx_a),      32'd0);
        chk({tag, "_b"},     32'(idx_b),      32'd0);
        chk({tag, "_tw"},    32'(tw_idx),     32'd0);
        chk({tag, "_stage"}, 32'(stage),      32'd0);
        chk({tag, "_last"},  32'(last_in_stage), 32'd0);
    endtask

    // Starts a run and walks it pair by pair; stops early (pair presented, not accepted) at stop_at.
    task automatic run_sched(input bit rnd, input int poke, input int stop_at);
        int         n;
        int         cyc;
        logic       pv;
        logic       pr;
        logic [2:0] pa;
        n = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pa = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("first_valid", 32'(pair_valid), 32'd1);
        while (n < 12 && cyc < 400) begin
            if (n == stop_at) break;
            if (pair_valid) begin
                chk("idx_a",  32'(idx_a),  32'(exp_a[n]));
                chk("idx_b",  32'(idx_b),  32'(exp_b[n]));
                chk("tw_idx", 32'(tw_idx), 32'(exp_tw[n]));
                chk("stage",  32'(stage),  32'(exp_st[n]));
                chk("last",   32'(last_in_stage), ((n % 4) == 3) ? 32'd1 : 32'd0);
                chk("busy",   32'(busy),   32'd1);
                if (pv && !pr) chk("hold_a", 32'(idx_a), 32'(pa));
            end
`ifndef FFT_SCHED_STAGE_BARRIER_EN
            chk("no_gap", 32'(pair_valid), 32'd1);
`endif
            pv = pair_valid;
            pa = idx_a;
            pair_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pr = pair_ready;
            start = (n == poke);
            if (pair_valid && pair_ready) n++;
            step();
            cyc++;
        end
        start = 1'b0;
        pair_ready = 1'b1;
        if (stop_at >= 12) begin
            chk("pairs", 32'(n), 32'd12);
`ifndef FFT_SCHED_STAGE_BARRIER_EN
            if (!rnd) chk("cycles", 32'(cyc), 32'd12);
`else
            chk("drain_valid", 32'(pair_valid), 32'd0);
            step();
`endif
            chk("done_pulse", 32'(done),       32'd1);
            chk("done_valid", 32'(pair_valid), 32'd0);
            chk("done_busy",  32'(busy),       32'd1);
            step();
            chk("after_done", 32'(done),       32'd0);
            chk("after_busy", 32'(busy),       32'd0);
            step();
            chk("single_done", 32'(done),      32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; pair_ready = 1'b1;
`ifdef FFT_SCHED_STAGE_BARRIER_EN
        bf_idle = 1'b1;
`endif
        #12;
        chk_zero("reset");
        #1 reset_n = 1'b1;
        step();
        chk_zero("idle");

        run_sched(1'b0, 99, 99);
        run_sched(1'b1, 99, 99);
        run_sched(1'b0, 5, 99);

        // abort on the stage1 (1,3) handshake cycle
        run_sched(1'b0, 99, 5);
        abort = 1'b1;
        pair_ready = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", 32'(pair_valid), 32'd0);
        chk("abort_busy",  32'(busy),       32'd0);
        chk("abort_done",  32'(done),       32'd0);
        step();
        chk("abort_done2", 32'(done),       32'd0);
        run_sched(1'b0, 99, 99);

        // asynchronous reset mid-stage2
        run_sched(1'b0, 99, 9);
        #3 reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        #2 reset_n = 1'b1;
        step();
        chk_zero("post_rst");
        run_sched(1'b0, 99, 99);

`ifdef FFT_SCHED_STAGE_BARRIER_EN
        bf_idle = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 4; p++) begin
                chk("bar_valid", 32'(pair_valid), 32'd1);
                chk("bar_a",     32'(idx_a),      32'(exp_a[s*4+p]));
                chk("bar_stage", 32'(stage),      32'(s));
                step();
            end
            for (int k = 0; k < 6; k++) begin
                chk("bar_gap",    32'(pair_valid), 32'd0);
                chk("bar_nodone", 32'(done),       32'd0);
                bf_idle = (k == 5);
                step();
            end
            bf_idle = 1'b0;
        end
        chk("bar_done", 32'(done), 32'd1);
        bf_idle = 1'b1;
        step();
        chk("bar_busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
